// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // Width of a requester index; a single requester bit is still one wire.
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin priority search: first valid requester at or above rr_ptr, wrapping.
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
)(
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [id_width(N_REQ)-1:0]    rr_ptr,
    output logic [id_width(N_REQ)-1:0]    winner,
    output logic                          any_req
);

    localparam int IDW = id_width(N_REQ);

    logic [IDW-1:0] idx;

    // Walk offsets from highest to lowest so the nearest requester to rr_ptr wins.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = IDW'((int'(rr_ptr) + i) % N_REQ);
            if (req_valid[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte streams, one grant at a time.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no owner; pick round-robin winner when any requester is valid
// SEND      | owner holds grant; issue tx_start once owner has a byte
// WAIT_ACK  | byte issued; wait for tx_busy to rise (bounded by ACK_TIMEOUT)
// WAIT_DONE | transmitter busy; on fall either send next byte or release
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int MAX_BURST   = 16,
    parameter int ACK_TIMEOUT = 64
)(
    input  logic                          clk,
    input  logic                          areset,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [N_REQ-1:0]              req_last,
    output logic [N_REQ-1:0]              req_ready,
    output logic [DATA_WIDTH-1:0]         tx_byte,
    output logic                          tx_start,
    input  logic                          tx_busy,
    output logic                          grant_active,
    output logic [id_width(N_REQ)-1:0]    grant_id,
    output logic                          err_timeout
);

    localparam int IDW = id_width(N_REQ);
    localparam int BW  = $clog2(MAX_BURST + 1);
    localparam int TW  = $clog2(ACK_TIMEOUT + 1);

    state_t                state, state_nxt;
    logic [IDW-1:0]        rr_ptr, rr_ptr_nxt;
    logic [IDW-1:0]        grant_id_nxt, winner;
    logic                  grant_active_nxt, any_req;
    logic [BW-1:0]         burst_cnt, burst_nxt;
    logic [TW-1:0]         to_cnt, to_nxt;
    logic                  last_flag, last_nxt;
    logic [DATA_WIDTH-1:0] tx_byte_nxt, sel_data;
    logic                  tx_start_nxt, err_nxt, sel_valid, sel_last, rel;
    logic [N_REQ-1:0]      req_ready_nxt;

    uart_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_req   (any_req)
    );

    // Select the current owner's handshake and data lanes.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_nxt        = state;
        rr_ptr_nxt       = rr_ptr;
        grant_id_nxt     = grant_id;
        grant_active_nxt = grant_active;
        burst_nxt        = burst_cnt;
        to_nxt           = to_cnt;
        last_nxt         = last_flag;
        tx_byte_nxt      = tx_byte;
        tx_start_nxt     = 1'b0;
        req_ready_nxt    = '0;
        err_nxt          = 1'b0;
        rel              = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_id_nxt     = winner;
                    grant_active_nxt = 1'b1;
                    state_nxt        = SEND;
                end
            end
            SEND: begin
                if (sel_valid) begin
                    tx_start_nxt            = 1'b1;
                    req_ready_nxt[grant_id] = 1'b1;
                    tx_byte_nxt             = sel_data;
                    last_nxt                = sel_last;
                    burst_nxt               = burst_cnt + 1'b1;
                    to_nxt                  = '0;
                    state_nxt               = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
                    err_nxt = 1'b1;
                    rel     = 1'b1;
                end else begin
                    to_nxt = to_cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_flag || burst_cnt == BW'(MAX_BURST)) begin
                        rel = 1'b1;
                    end else begin
                        state_nxt = SEND;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Release hands priority to the requester after the owner.
        if (rel) begin
            grant_active_nxt = 1'b0;
            burst_nxt        = '0;
            rr_ptr_nxt       = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            state_nxt        = IDLE;
        end
    end

    // State, counters and registered outputs; reset aborts any grant in flight.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            burst_cnt    <= '0;
            to_cnt       <= '0;
            last_flag    <= 1'b0;
            tx_byte      <= '0;
            tx_start     <= 1'b0;
            req_ready    <= '0;
            err_timeout  <= 1'b0;
        end else begin
            state        <= state_nxt;
            rr_ptr       <= rr_ptr_nxt;
            grant_id     <= grant_id_nxt;
            grant_active <= grant_active_nxt;
            burst_cnt    <= burst_nxt;
            to_cnt       <= to_nxt;
            last_flag    <= last_nxt;
            tx_byte      <= tx_byte_nxt;
            tx_start     <= tx_start_nxt;
            req_ready    <= req_ready_nxt;
            err_timeout  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester queues, a transmitter
// model, a start-event monitor and a message-level round-robin reference.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int AT = 20;

    logic            clk = 1'b0;
    logic            areset = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   tx_byte;
    logic            tx_start;
    logic            tx_busy = 1'b0;
    logic            grant_active;
    logic [1:0]      grant_id;
    logic            err_timeout;

    uart_tx_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .ACK_TIMEOUT(AT)) dut (
        .clk          (clk),
        .areset       (areset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_byte      (tx_byte),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .grant_active (grant_active),
        .grant_id     (grant_id),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Requester side: each queue holds {last, data}; valid while non-empty.
    logic [DW:0] rq [N][$];
    int gen_cnt [N];

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (areset && req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            if (rq[i].size() > 0) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = rq[i][0][DW-1:0];
                req_last[i]           = rq[i][0][DW];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = '0;
                req_last[i]           = 1'b0;
            end
        end
    end

    // Transmitter model: busy rises rise_dly cycles after tx_start, stays busy_len cycles.
    int rise_dly = 1;
    int busy_len = 4;
    bit tied0    = 1'b0;
    bit pending  = 1'b0;
    int rise_left = 0;
    int busy_left = 0;

    always @(negedge clk) begin
        if (tied0) begin
            tx_busy = 1'b0;
            pending = 1'b0;
        end else begin
            if (tx_start) begin
                pending   = 1'b1;
                rise_left = rise_dly;
            end
            if (tx_busy) begin
                busy_left--;
                if (busy_left <= 0) tx_busy = 1'b0;
            end else if (pending) begin
                if (rise_left == 0) begin
                    tx_busy   = 1'b1;
                    busy_left = busy_len;
                    pending   = 1'b0;
                end else begin
                    rise_left--;
                end
            end
        end
    end

    // Monitor: log every start, check per-cycle handshake rules.
    int          obs_owner [$];
    logic [DW-1:0] obs_byte [$];
    int          start_count = 0;
    bit          armed = 1'b0;
    bit          expect_to = 1'b0;
    logic        busy_q = 1'b0;
    logic        busy_qq = 1'b0;
    logic        prev_ga = 1'b0;

    always @(posedge clk) busy_q <= tx_busy;

    always @(negedge clk) begin
        if (!areset) begin
            armed   = 1'b0;
            prev_ga = 1'b0;
        end else begin
            if (busy_qq && !busy_q) armed = 1'b0;
            busy_qq = busy_q;
            if (tx_start) begin
                start_count++;
                obs_owner.push_back(int'(grant_id));
                obs_byte.push_back(tx_byte);
                check("ready_onehot", 32'(req_ready), 32'(1) << grant_id);
                check("grant_at_start", 32'(grant_active), 1);
                check("start_after_busy_fall", 32'(armed), 0);
                armed = 1'b1;
            end else begin
                check("ready_without_start", 32'(req_ready), 0);
            end
            if (!expect_to) check("no_timeout", 32'(err_timeout), 0);
            if (err_timeout) armed = 1'b0;
            if (prev_ga && !grant_active && !err_timeout) check("release_busy_low", 32'(busy_q), 0);
            prev_ga = grant_active;
        end
    end

    int exp_q [$];

    task automatic do_reset();
        areset    = 1'b0;
        expect_to = 1'b0;
        tied0     = 1'b0;
        for (int i = 0; i < N; i++) rq[i].delete();
        repeat (3) @(negedge clk);
        check("reset_outputs",
              32'({grant_active, tx_start, err_timeout, req_ready, tx_byte, grant_id}), 0);
        areset = 1'b1;
        obs_owner.delete();
        obs_byte.delete();
        for (int i = 0; i < N; i++) gen_cnt[i] = 0;
        @(negedge clk);
        #1;
    endtask

    // Each requester i queues nb[4i+:4] bytes {i, seq}, last on the final one.
    task automatic push_msgs(input logic [15:0] nb);
        int n;
        for (int i = 0; i < N; i++) begin
            n = int'(nb[4*i +: 4]);
            for (int k = 0; k < n; k++) begin
                rq[i].push_back({(k == n - 1), 4'(i), 4'(gen_cnt[i])});
                gen_cnt[i]++;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        int quiet = 0;
        bit empty;
        while (quiet < 4 && k < 3000) begin
            @(negedge clk);
            k++;
            empty = 1'b1;
            for (int i = 0; i < N; i++) if (rq[i].size() > 0) empty = 1'b0;
            if (empty && !grant_active && !tx_busy && !pending) quiet++;
            else quiet = 0;
        end
        check({name, "_drained"}, 32'(k < 3000), 1);
    endtask

    // Reference: message-level round robin with a per-grant byte cap.
    task automatic model(input logic [15:0] nb);
        int rem [N];
        int ptr = 0;
        int o;
        int sent;
        exp_q.delete();
        for (int i = 0; i < N; i++) rem[i] = int'(nb[4*i +: 4]);
        while (1) begin
            o = -1;
            for (int s = 0; s < N; s++)
                if (o < 0 && rem[(ptr + s) % N] > 0) o = (ptr + s) % N;
            if (o < 0) break;
            sent = 0;
            do begin
                exp_q.push_back(o);
                rem[o]--;
                sent++;
            end while (rem[o] > 0 && sent < MB);
            ptr = (o + 1) % N;
        end
    endtask

    task automatic compare(input string name);
        int ecnt [N];
        int o;
        int m;
        for (int i = 0; i < N; i++) ecnt[i] = 0;
        check({name, "_count"}, obs_owner.size(), exp_q.size());
        m = (obs_owner.size() < exp_q.size()) ? obs_owner.size() : exp_q.size();
        for (int j = 0; j < m; j++) begin
            o = exp_q[j];
            check({name, "_owner"}, obs_owner[j], o);
            check({name, "_byte"}, 32'(obs_byte[j]), 32'({4'(o), 4'(ecnt[o])}));
            ecnt[o]++;
        end
    endtask

    typedef struct {
        string       name;
        logic [15:0] prime;
        logic [15:0] nb;
        int          rise;
        int          blen;
        int          exp_n;
        logic [63:0] seq;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [63:0] seq;
        logic [15:0] nb;
        int k;
        int sc;

        vecs[0] = '{"single",    16'h0000, 16'h0001, 1, 10, 1, 64'h0};
        vecs[1] = '{"rr4",       16'h0000, 16'h1111, 0, 3,  4, 64'h3210};
        vecs[2] = '{"rr_offset", 16'h0001, 16'h0101, 2, 2,  3, 64'h020};
        vecs[3] = '{"msg_lock",  16'h0001, 16'h0031, 1, 4,  5, 64'h01110};
        vecs[4] = '{"burst_cap", 16'h0000, 16'h1600, 1, 2,  7, 64'h2232222};
        vecs[5] = '{"rr_wrap",   16'h0100, 16'h1011, 3, 1,  4, 64'h1032};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            rise_dly = vecs[v].rise;
            busy_len = vecs[v].blen;
            seq = vecs[v].seq;
            exp_q.delete();
            for (int j = 0; j < vecs[v].exp_n; j++) exp_q.push_back(int'(seq[4*j +: 4]));
            if (vecs[v].prime != 16'h0) begin
                push_msgs(vecs[v].prime);
                wait_idle({vecs[v].name, "_prime"});
            end
            push_msgs(vecs[v].nb);
            wait_idle(vecs[v].name);
            compare(vecs[v].name);
        end

        // Ack timeout with the transmitter never going busy.
        do_reset();
        tied0     = 1'b1;
        expect_to = 1'b1;
        rq[0].push_back({1'b1, 8'h5A});
        @(negedge clk);
        @(negedge clk);
        check("lat_grant", 32'({grant_active, tx_start}), 32'b10);
        @(negedge clk);
        check("lat_start", 32'(tx_start), 1);
        check("to_byte", 32'(tx_byte), 32'h5A);
        check("to_grant_id", 32'(grant_id), 0);
        k = 0;
        while (!err_timeout && k < AT + 10) begin
            @(negedge clk);
            k++;
        end
        check("to_cycles", k, AT);
        check("to_released", 32'(grant_active), 0);
        @(negedge clk);
        check("to_pulse_width", 32'(err_timeout), 0);
        tied0     = 1'b0;
        expect_to = 1'b0;
        rise_dly  = 1;
        busy_len  = 3;
        obs_owner.delete();
        obs_byte.delete();
        for (int i = 0; i < N; i++) gen_cnt[i] = 0;
        exp_q.delete();
        exp_q.push_back(1);
        exp_q.push_back(0);
        push_msgs(16'h0011);
        wait_idle("to_rr");
        compare("to_rr");

        // Reset while the transmitter is busy.
        do_reset();
        rise_dly = 0;
        busy_len = 30;
        push_msgs(16'h0020);
        k = 0;
        while (!tx_start && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("mr_start_seen", 32'(tx_start), 1);
        repeat (5) @(negedge clk);
        check("mr_in_transfer", 32'(grant_active), 1);
        #2 areset = 1'b0;
        #1;
        check("mr_async_outputs",
              32'({grant_active, tx_start, err_timeout, req_ready, tx_byte, grant_id}), 0);
        for (int i = 0; i < N; i++) rq[i].delete();
        sc = start_count;
        repeat (3) @(negedge clk);
        areset = 1'b1;
        repeat (40) @(negedge clk);
        check("mr_no_start", start_count, sc);
        check("mr_idle", 32'(grant_active), 0);
        for (int i = 0; i < N; i++) gen_cnt[i] = 0;
        busy_len = 3;
        push_msgs(16'h0100);
        k = 0;
        while (!tx_start && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("mr_restart", 32'(tx_start), 1);
        check("mr_restart_id", 32'(grant_id), 2);
        wait_idle("mr_final");

        // Randomised traffic against the reference.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            rise_dly = $urandom_range(0, 3);
            busy_len = $urandom_range(1, 5);
            nb = '0;
            for (int i = 0; i < N; i++) nb[4*i +: 4] = 4'($urandom_range(0, 6));
            model(nb);
            push_msgs(nb);
            wait_idle("rand");
            compare("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1);
    end

endmodule
